// File: rtl/mips_pkg.sv
// Shared widths, load-type codes and the MEM->WB register layout for the writeback stage.
package mips_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] LT_LW  = 3'd0;
   localparam logic [2:0] LT_LB  = 3'd1;
   localparam logic [2:0] LT_LBU = 3'd2;
   localparam logic [2:0] LT_LH  = 3'd3;
   localparam logic [2:0] LT_LHU = 3'd4;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic              regwrite;
      logic              memtoreg;
      logic [2:0]        load_type;
      logic [1:0]        addr_lo;
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   mem_rdata;
      logic [REG_AW-1:0] wa;
   } wb_reg_t;

   localparam wb_reg_t WB_RESET = '0;

endpackage

// File: rtl/load_extract.sv
// Little-endian load alignment and sign/zero extension of a raw memory word.
module load_extract
   import mips_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      load_type,
   output logic [XLEN-1:0] data_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Codes outside the defined set fall through to a full-word load.
   always_comb begin
      data_ext = rdata;
      case (load_type)
         LT_LB:   data_ext = {{24{byte_sel[7]}}, byte_sel};
         LT_LBU:  data_ext = {24'h000000, byte_sel};
         LT_LH:   data_ext = {{16{half_sel[15]}}, half_sel};
         LT_LHU:  data_ext = {16'h0000, half_sel};
         default: data_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register, writeback mux, $0 write suppression and retired-instruction counter.
// Optional trace port group enabled by defining MEMWB_TRACE_EN.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                stall_w,
   input  logic                flush_w,
   input  logic                m_valid,
   input  logic [XLEN-1:0]     m_pc,
   input  logic                m_regwrite,
   input  logic                m_memtoreg,
   input  logic [2:0]          m_load_type,
   input  logic [1:0]          m_addr_lo,
   input  logic [XLEN-1:0]     m_alu_result,
   input  logic [XLEN-1:0]     m_mem_rdata,
   input  logic [REG_AW-1:0]   m_wa,
   output logic                we3,
   output logic [REG_AW-1:0]   wa3,
   output logic [XLEN-1:0]     wd3,
   output logic                w_valid,
   output logic [XLEN-1:0]     w_pc,
   output logic [CNT_W-1:0]    instret
`ifdef MEMWB_TRACE_EN
   ,
   output logic [XLEN-1:0]     debug_wb_pc,
   output logic [3:0]          debug_wb_rf_wen,
   output logic [REG_AW-1:0]   debug_wb_rf_wnum,
   output logic [XLEN-1:0]     debug_wb_rf_wdata
`endif
);

   wb_reg_t          wb_q, wb_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [XLEN-1:0]  load_data;
   logic             retire;

   // Control contract: flush_w inserts a bubble and beats stall_w; stall_w freezes
   // the WB register; otherwise the MEM slot is captured every cycle.
   always_comb begin
      wb_d = wb_q;
      if (flush_w) begin
         wb_d.valid    = 1'b0;
         wb_d.regwrite = 1'b0;
      end else if (!stall_w) begin
         wb_d.valid      = m_valid;
         wb_d.pc         = m_pc;
         wb_d.regwrite   = m_regwrite;
         wb_d.memtoreg   = m_memtoreg;
         wb_d.load_type  = m_load_type;
         wb_d.addr_lo    = m_addr_lo;
         wb_d.alu_result = m_alu_result;
         wb_d.mem_rdata  = m_mem_rdata;
         wb_d.wa         = m_wa;
      end
   end

   // A stalled instruction is counted only on the cycle it finally leaves WB.
   assign retire    = wb_q.valid & ~stall_w;
   assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb_q      <= WB_RESET;
         instret_q <= '0;
      end else begin
         wb_q      <= wb_d;
         instret_q <= instret_d;
      end
   end

   load_extract u_load_extract (
      .rdata     (wb_q.mem_rdata),
      .addr_lo   (wb_q.addr_lo),
      .load_type (wb_q.load_type),
      .data_ext  (load_data)
   );

   assign we3     = wb_q.valid & wb_q.regwrite & (wb_q.wa != '0);
   assign wa3     = wb_q.wa;
   assign wd3     = wb_q.memtoreg ? load_data : wb_q.alu_result;
   assign w_valid = wb_q.valid;
   assign w_pc    = wb_q.pc;
   assign instret = instret_q;

`ifdef MEMWB_TRACE_EN
   assign debug_wb_pc       = wb_q.pc;
   assign debug_wb_rf_wen   = {4{we3 & ~stall_w}};
   assign debug_wb_rf_wnum  = wa3;
   assign debug_wb_rf_wdata = wd3;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;

   localparam int CNT_W = 6;
   localparam int CNT_MOD = 1 << CNT_W;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        stall_w = 1'b0, flush_w = 1'b0;
   logic        m_valid = 1'b0, m_regwrite = 1'b0, m_memtoreg = 1'b0;
   logic [31:0] m_pc = '0, m_alu_result = '0, m_mem_rdata = '0;
   logic [2:0]  m_load_type = '0;
   logic [1:0]  m_addr_lo = '0;
   logic [4:0]  m_wa = '0;
   logic        we3, w_valid;
   logic [4:0]  wa3;
   logic [31:0] wd3, w_pc;
   logic [CNT_W-1:0] instret;
`ifdef MEMWB_TRACE_EN
   logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   int          trace_recs;
`endif

   int errors = 0;
   int checks = 0;

   mem_wb_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .stall_w(stall_w), .flush_w(flush_w),
      .m_valid(m_valid), .m_pc(m_pc), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
      .m_load_type(m_load_type), .m_addr_lo(m_addr_lo), .m_alu_result(m_alu_result),
      .m_mem_rdata(m_mem_rdata), .m_wa(m_wa),
      .we3(we3), .wa3(wa3), .wd3(wd3), .w_valid(w_valid), .w_pc(w_pc), .instret(instret)
`ifdef MEMWB_TRACE_EN
      , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the instruction currently sitting in WB plus a retire count.
   logic        r_valid, r_rw, r_m2r;
   logic [31:0] r_pc, r_alu, r_rd;
   logic [2:0]  r_lt;
   logic [1:0]  r_alo;
   logic [4:0]  r_wa;
   int          r_cnt;

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] alo,
                                            input logic [2:0] lt);
      int unsigned b, h;
      b = (word >> (8 * alo)) % 256;
      h = (word >> (16 * alo[1])) % 65536;
      case (lt)
         3'd1:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
         3'd2:    return 32'(b);
         3'd3:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
         3'd4:    return 32'(h);
         default: return word;
      endcase
   endfunction

   function automatic logic ref_we();
      return r_valid && r_rw && (r_wa != 0);
   endfunction

   function automatic logic [31:0] ref_wd();
      return r_m2r ? ref_load(r_rd, r_alo, r_lt) : r_alu;
   endfunction

   task automatic model_reset();
      r_valid = 0; r_rw = 0; r_m2r = 0; r_pc = 0; r_alu = 0; r_rd = 0;
      r_lt = 0; r_alo = 0; r_wa = 0; r_cnt = 0;
   endtask

   task automatic model_edge();
      if (!resetn) begin
         model_reset();
      end else begin
         if (r_valid && !stall_w) r_cnt = (r_cnt + 1) % CNT_MOD;
         if (flush_w) begin
            r_valid = 0; r_rw = 0;
         end else if (!stall_w) begin
            r_valid = m_valid; r_rw = m_regwrite; r_m2r = m_memtoreg; r_pc = m_pc;
            r_alu = m_alu_result; r_rd = m_mem_rdata; r_lt = m_load_type;
            r_alo = m_addr_lo; r_wa = m_wa;
         end
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check_val("we3", 32'(we3), 32'(ref_we()));
      check_val("wa3", 32'(wa3), 32'(r_wa));
      check_val("wd3", wd3, ref_wd());
      check_val("w_valid", 32'(w_valid), 32'(r_valid));
      check_val("w_pc", w_pc, r_pc);
      check_val("instret", 32'(instret), 32'(r_cnt));
`ifdef MEMWB_TRACE_EN
      check_val("dbg_wen", 32'(debug_wb_rf_wen), {28'h0, {4{ref_we() & ~stall_w}}});
      check_val("dbg_pc", debug_wb_pc, r_pc);
      check_val("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(r_wa));
      check_val("dbg_wdata", debug_wb_rf_wdata, ref_wd());
`endif
   endtask

   // Inputs are changed only at the negedge, after that cycle's checks.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic slot(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [1:0] alo, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] wa);
      m_valid = v; m_regwrite = rw; m_memtoreg = m2r; m_load_type = lt; m_addr_lo = alo;
      m_alu_result = alu; m_mem_rdata = rd; m_wa = wa; m_pc = m_pc + 32'd4;
   endtask

   task automatic load_case(input string tag, input logic [2:0] lt, input logic [1:0] alo,
                            input logic [31:0] exp);
      slot(1, 1, 1, lt, alo, 32'hDEAD0000, 32'h80FF7F01, 5'd3);
      cycle();
      check_val(tag, wd3, exp);
   endtask

   int base;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_we3", 32'(we3), 32'h0);
      check_val("rst_wd3", wd3, 32'h0);
      check_val("rst_instret", 32'(instret), 32'h0);
      check_all();
      resetn = 1'b1;

      // ALU writeback
      slot(1, 1, 0, 3'd0, 2'd0, 32'h1234, 32'h0, 5'd8);
      cycle();
      check_val("alu_we3", 32'(we3), 32'h1);
      check_val("alu_wa3", 32'(wa3), 32'd8);
      check_val("alu_wd3", wd3, 32'h1234);
      slot(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
      cycle();
      check_val("alu_instret", 32'(instret), 32'd1);

      load_case("lb2", 3'd1, 2'd2, 32'hFFFFFFFF);
      load_case("lbu3", 3'd2, 2'd3, 32'h00000080);
      load_case("lh2", 3'd3, 2'd2, 32'hFFFF80FF);
      load_case("lhu0", 3'd4, 2'd0, 32'h00007F01);
      load_case("lhu1", 3'd4, 2'd1, 32'h00007F01);
      load_case("lw", 3'd0, 2'd1, 32'h80FF7F01);
      load_case("code6", 3'd6, 2'd3, 32'h80FF7F01);

      // $0 write suppressed, still retires
      slot(1, 1, 0, 3'd0, 2'd0, 32'hABCD, 32'h0, 5'd0);
      cycle();
      check_val("r0_we3", 32'(we3), 32'h0);
      base = r_cnt;
      slot(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
      cycle();
      check_val("r0_instret", 32'(instret), 32'((base + 1) % CNT_MOD));

      // Stall three cycles, then release
      slot(1, 1, 0, 3'd0, 2'd0, 32'h5555, 32'h0, 5'd9);
      cycle();
      base = r_cnt;
      stall_w = 1'b1;
      slot(1, 1, 0, 3'd0, 2'd0, 32'h7777, 32'h0, 5'd10);
`ifdef MEMWB_TRACE_EN
      trace_recs = 0;
`endif
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_val("stall_wd3", wd3, 32'h5555);
      end
      stall_w = 1'b0;
      slot(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
`ifdef MEMWB_TRACE_EN
      if (debug_wb_rf_wen == 4'hF) trace_recs++;
`endif
      cycle();
      check_val("stall_instret", 32'(instret), 32'((base + 1) % CNT_MOD));
`ifdef MEMWB_TRACE_EN
      check_val("trace_once", 32'(trace_recs), 32'd1);
`endif

      // Flush beats stall
      slot(1, 1, 0, 3'd0, 2'd0, 32'h1111, 32'h0, 5'd4);
      cycle();
      stall_w = 1'b1; flush_w = 1'b1;
      cycle();
      check_val("flush_valid", 32'(w_valid), 32'h0);
      check_val("flush_we3", 32'(we3), 32'h0);
      stall_w = 1'b0; flush_w = 1'b0;

      // Asynchronous reset between edges
      slot(1, 1, 0, 3'd0, 2'd0, 32'h2222, 32'h0, 5'd5);
      cycle();
      #2 resetn = 1'b0;
      #1;
      check_val("arst_we3", 32'(we3), 32'h0);
      check_val("arst_wd3", wd3, 32'h0);
      check_val("arst_valid", 32'(w_valid), 32'h0);
      check_val("arst_instret", 32'(instret), 32'h0);
      model_reset();
      cycle();
      resetn = 1'b1;

      // Counter wrap at 2^CNT_W
      for (int i = 0; i < 200 && r_cnt != CNT_MOD - 1; i++) begin
         slot(1, 1, 0, 3'd0, 2'd0, 32'(i), 32'h0, 5'd1);
         cycle();
      end
      check_val("pre_wrap", 32'(instret), 32'(CNT_MOD - 1));
      cycle();
      check_val("wrap", 32'(instret), 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         stall_w = ($urandom_range(0, 4) == 0);
         flush_w = ($urandom_range(0, 9) == 0);
         slot(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
              2'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not finish at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
